// File: rtl/swc_ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and lane-strobe helper for the TCM slaves.
// The ERR states exist only when DTCM_ERR_RESP_EN is defined.
package swc_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1
`ifdef DTCM_ERR_RESP_EN
    ,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
`endif
  } swc_state_e;

  // Lanes above byte 3 fall off the 4-bit result, so misaligned halves truncate naturally.
  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << off;
      HSIZE_HALF: s = 4'b0011 << off;
      default:    s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dtcm_ram_swc.sv
// Byte-strobed word array: one synchronous write port, one combinational read port.
// Contents are never reset.
module dtcm_ram_swc #(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12,
  parameter     INIT_FILE   = ""
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dtcm_ahb_swc.sv
// DTCM AHB-Lite slave: pipelined address/data phases, lane strobes, programmable wait states.
// Define DTCM_ERR_RESP_EN to return two-cycle ERROR responses for illegal accesses.
//
// state   | meaning
// IDLE    | no pending data phase, hready=1
// DATA    | data phase, wcnt counts wait cycles, completes when wcnt==WAIT_STATES
// ERR1    | first error cycle, hresp=1 hready=0
// ERR2    | second error cycle, hresp=1 hready=1
module dtcm_ahb_swc
  import swc_ahb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 0,
  parameter              INIT_FILE   = ""
) (
  input  logic        hclk,
  input  logic        hrstn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp
);

  localparam int         AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [1:0] WS = 2'(WAIT_STATES);

  swc_state_e    state_q, state_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic          take, final_data, err_cyc, trans_act, active, legal;
  logic [AW-1:0] dp_idx;
  logic [1:0]    dp_off;
  logic [2:0]    dp_size;
  logic          dp_write;
  logic          mem_we;
  logic [31:0]   rd_word;

  assign trans_act = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  assign active    = hsel & trans_act & take;

`ifdef DTCM_ERR_RESP_EN
  localparam logic [31:0] WIN_MASK = 32'(DEPTH_WORDS * 4 - 1);
  logic in_win, aligned;
  assign in_win  = (haddr & ~WIN_MASK) == BASE_ADDR;
  assign aligned = (hsize == HSIZE_BYTE) ||
                   ((hsize == HSIZE_HALF) && !haddr[0]) ||
                   ((hsize == HSIZE_WORD) && (haddr[1:0] == 2'b00));
  assign legal   = in_win & aligned;
`else
  // Without error responses every access is served; high address bits simply alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^haddr[31:AW+2];
  assign legal          = 1'b1;
`endif

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    take       = 1'b1;
    final_data = 1'b0;
    err_cyc    = 1'b0;
    case (state_q)
      ST_DATA: begin
        if (wcnt_q != WS) begin
          take   = 1'b0;
          wcnt_d = wcnt_q + 2'd1;
        end else begin
          final_data = 1'b1;
        end
      end
`ifdef DTCM_ERR_RESP_EN
      ST_ERR1: begin
        take    = 1'b0;
        err_cyc = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: err_cyc = 1'b1;
`endif
      default: ;
    endcase
    // A completing cycle doubles as the sampling point for the next address phase.
    if (take) begin
      wcnt_d = 2'd0;
      if (hsel && trans_act) begin
`ifdef DTCM_ERR_RESP_EN
        state_d = legal ? ST_DATA : ST_ERR1;
`else
        state_d = ST_DATA;
`endif
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      dp_idx   <= '0;
      dp_off   <= 2'd0;
      dp_size  <= 3'd0;
      dp_write <= 1'b0;
    end else if (active) begin
      dp_idx   <= haddr[AW+1:2];
      dp_off   <= haddr[1:0];
      dp_size  <= hsize;
      dp_write <= hwrite & legal;
    end
  end

  assign hready = take;
  assign hresp  = err_cyc ? HRESP_ERROR : HRESP_OKAY;
  assign mem_we = final_data & dp_write;
  assign hrdata = (final_data && !dp_write) ? rd_word : 32'd0;

  dtcm_ram_swc #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk  (hclk),
    .we   (mem_we),
    .wstrb(lane_strb(dp_size, dp_off)),
    .waddr(dp_idx),
    .wdata(hwdata),
    .raddr(dp_idx),
    .rdata(rd_word)
  );

endmodule

// File: tb/tb_dtcm_ahb_swc.sv
// Self-checking bench for dtcm_ahb_swc: three instances (W=0,2,3) share one master,
// only the selected one sees non-IDLE htrans; a transaction-level model predicts every cycle.
module tb_dtcm_ahb_swc;
  import swc_ahb_pkg::*;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0001_0000;

  typedef struct {
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  logic        hclk = 1'b0;
  logic        hrstn, hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [1:0]  dsel;

  logic [1:0]  htrans_v [3];
  logic [31:0] hrdata_v [3];
  logic [2:0]  hready_v, hresp_v;
  logic [31:0] hrdata_m;
  logic        hready_m, hresp_m;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mdl [3][DEPTH];
  op_t         q [$];
  logic [31:0] last_rd;
  int          low_cycles, resp_cycles;

  always #5 hclk = ~hclk;

  for (genvar k = 0; k < 3; k++) begin : g_sel
    assign htrans_v[k] = (dsel == 2'(k)) ? htrans : HTRANS_IDLE;
  end

  assign hrdata_m = hrdata_v[dsel];
  assign hready_m = hready_v[dsel];
  assign hresp_m  = hresp_v[dsel];

  dtcm_ahb_swc #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
    .hclk(hclk), .hrstn(hrstn), .hsel(hsel), .haddr(haddr), .htrans(htrans_v[0]),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(hrdata_v[0]), .hready(hready_v[0]), .hresp(hresp_v[0]));

  dtcm_ahb_swc #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(2)) u_dut1 (
    .hclk(hclk), .hrstn(hrstn), .hsel(hsel), .haddr(haddr), .htrans(htrans_v[1]),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(hrdata_v[1]), .hready(hready_v[1]), .hresp(hresp_v[1]));

  dtcm_ahb_swc #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut2 (
    .hclk(hclk), .hrstn(hrstn), .hsel(hsel), .haddr(haddr), .htrans(htrans_v[2]),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata),
    .hrdata(hrdata_v[2]), .hready(hready_v[2]), .hresp(hresp_v[2]));

  function automatic int ws_of(int s);
    return (s == 0) ? 0 : (s == 1) ? 2 : 3;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit is_err(op_t o);
`ifdef DTCM_ERR_RESP_EN
    return (o.size > 3'd2) || (o.size == 3'd1 && o.addr[0]) ||
           (o.size == 3'd2 && o.addr[1:0] != 2'b00) ||
           (o.addr < BASE) || (o.addr >= BASE + DEPTH * 4);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model_write(int s, op_t o);
    logic [31:0] w;
    int off;
    bit hit;
    w   = mdl[s][widx(o.addr)];
    off = int'(o.addr[1:0]);
    for (int b = 0; b < 4; b++) begin
      if (o.size == 3'd0)      hit = (b == off);
      else if (o.size == 3'd1) hit = (b == off) || (b == off + 1);
      else                     hit = 1'b1;
      if (hit) w[8*b +: 8] = o.wdata[8*b +: 8];
    end
    mdl[s][widx(o.addr)] = w;
  endfunction

  function automatic op_t mk(logic [1:0] tr, bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
    op_t o;
    o.sel = 1'b1; o.trans = tr; o.write = wr; o.size = sz; o.addr = a; o.wdata = d;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  r;
    o.sel   = ($urandom_range(0, 9) != 0);
    r       = $urandom_range(0, 9);
    o.trans = (r == 0) ? HTRANS_IDLE : (r == 1) ? HTRANS_BUSY : (r < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
    o.write = 1'($urandom_range(0, 1));
    o.size  = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    o.addr  = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
    if (o.size == 3'd0) o.addr[1:0] = 2'($urandom_range(0, 3));
    if (o.size == 3'd1) o.addr[1]   = 1'($urandom_range(0, 1));
    r = $urandom_range(0, 19);
    if (r == 0) o.addr[1:0] = 2'($urandom_range(0, 3));
    if (r == 1) o.addr = o.addr + 32'(DEPTH * 4 * $urandom_range(1, 3));
    if (r == 2) o.addr = BASE - 32'd4;
    o.wdata = $urandom;
    return o;
  endfunction

  // Drives the queued ops as a pipelined master and checks every cycle against the model.
  task automatic run_ops();
    op_t         cur;
    bit          cur_v, cur_err, exp_rdy, exp_resp;
    int          cnt, guard, s;
    logic [31:0] exp_rd;
    cur_v = 1'b0; cur_err = 1'b0; cnt = 0; guard = 0;
    low_cycles = 0; resp_cycles = 0;
    s = int'(dsel);
    while ((q.size() > 0 || cur_v) && guard < 4000) begin
      @(negedge hclk);
      guard++;
      exp_rdy = 1'b1; exp_resp = 1'b0; exp_rd = 32'd0;
      if (cur_v) begin
        if (cur_err) begin
          exp_resp = 1'b1;
          exp_rdy  = (cnt >= 1);
        end else begin
          exp_rdy = (cnt >= ws_of(s));
          if (exp_rdy && !cur.write) exp_rd = mdl[s][widx(cur.addr)];
        end
      end
      checks++;
      if (hready_m !== exp_rdy) begin
        failures++;
        $display("FAIL hready inst%0d addr %h cyc %0d: got %b expected %b", s, cur.addr, cnt, hready_m, exp_rdy);
      end
      checks++;
      if (hresp_m !== exp_resp) begin
        failures++;
        $display("FAIL hresp inst%0d addr %h cyc %0d: got %b expected %b", s, cur.addr, cnt, hresp_m, exp_resp);
      end
      checks++;
      if (hrdata_m !== exp_rd) begin
        failures++;
        $display("FAIL hrdata inst%0d addr %h cyc %0d: got %h expected %h", s, cur.addr, cnt, hrdata_m, exp_rd);
      end
      if (!hready_m) low_cycles++;
      if (hresp_m) resp_cycles++;
      if (cur_v && !cur_err && !cur.write && exp_rdy) last_rd = hrdata_m;

      hwdata = (cur_v && cur.write) ? cur.wdata : $urandom;
      if (q.size() > 0) begin
        hsel = q[0].sel; htrans = q[0].trans; hwrite = q[0].write;
        hsize = q[0].size; haddr = q[0].addr;
      end else begin
        hsel = 1'b1; htrans = HTRANS_IDLE; hwrite = 1'b0; hsize = HSIZE_WORD; haddr = $urandom;
      end

      if (exp_rdy) begin
        if (cur_v && !cur_err && cur.write) model_write(s, cur);
        cur_v = 1'b0;
        if (q.size() > 0) begin
          if (q[0].sel && q[0].trans[1]) begin
            cur = q[0]; cur_v = 1'b1; cnt = 0; cur_err = is_err(cur);
          end
          void'(q.pop_front());
        end
      end else begin
        cnt++;
      end
    end
    if (guard >= 4000) begin
      checks++; failures++;
      $display("FAIL run_ops timeout: got %0d cycles required < 4000", guard);
      q.delete();
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      dsel = 2'(k);
      #1;
      checks++;
      if (hready_m !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 32'd0) begin
        failures++;
        $display("FAIL reset_outputs inst%0d: got rdy=%b resp=%b rd=%h expected 1 0 0", k, hready_m, hresp_m, hrdata_m);
      end
    end
    dsel = 2'd0;
    @(negedge hclk); hrstn = 1'b1;
    @(negedge hclk);
    checks++;
    if (hready_m !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 32'd0) begin
      failures++;
      $display("FAIL post_reset_idle: got rdy=%b resp=%b rd=%h expected 1 0 0", hready_m, hresp_m, hrdata_m);
    end
  endtask

  task automatic test_preload();
    for (int k = 0; k < 3; k++) begin
      dsel = 2'(k);
      for (int i = 0; i < DEPTH; i++)
        q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'(4 * i), $urandom));
      run_ops();
    end
  endtask

  task automatic test_word_roundtrip();
    dsel = 2'd0;
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h10, 32'hDEADBEEF));
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h10, 32'h0));
    run_ops();
    checks++;
    if (last_rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL word_roundtrip: got %h expected deadbeef", last_rd);
    end
    checks++;
    if (low_cycles !== 0) begin
      failures++;
      $display("FAIL zero_wait_ready: got %0d low cycles expected 0", low_cycles);
    end
  endtask

  task automatic test_lanes();
    dsel = 2'd0;
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h20, 32'h11223344));
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, BASE + 32'h22, 32'h00AA0000));
    q.push_back(mk(HTRANS_SEQ,    1'b1, HSIZE_HALF, BASE + 32'h20, 32'h0000BBCC));
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h20, 32'h0));
    run_ops();
    checks++;
    if (last_rd !== 32'h11AABBCC) begin
      failures++;
      $display("FAIL byte_half_lanes: got %h expected 11aabbcc", last_rd);
    end
  endtask

  task automatic test_wait_states();
    dsel = 2'd1;
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h30, 32'hCAFE0123));
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h30, 32'h0));
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h34, 32'h0));
    run_ops();
    checks++;
    if (low_cycles !== 6) begin
      failures++;
      $display("FAIL wait_low_cycles: got %0d expected 6", low_cycles);
    end
    checks++;
    if (last_rd !== mdl[1][13]) begin
      failures++;
      $display("FAIL wait_read_data: got %h expected %h", last_rd, mdl[1][13]);
    end
  endtask

  task automatic test_error();
    int exp_resp0, exp_resp1, exp_low1;
    logic [31:0] w0, w2;
`ifdef DTCM_ERR_RESP_EN
    exp_resp0 = 6; exp_resp1 = 2; exp_low1 = 3;
`else
    exp_resp0 = 0; exp_resp1 = 0; exp_low1 = 4;
`endif
    dsel = 2'd0;
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h2, 32'h0BAD0001));
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + DEPTH * 4, 32'h0BAD0002));
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, 3'd3, BASE + 32'h8, 32'h0BAD0003));
    run_ops();
    checks++;
    if (resp_cycles !== exp_resp0) begin
      failures++;
      $display("FAIL error_resp_cycles: got %0d expected %0d", resp_cycles, exp_resp0);
    end
    w0 = mdl[0][0]; w2 = mdl[0][2];
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE, 32'h0));
    run_ops();
    checks++;
    if (last_rd !== w0) begin
      failures++;
      $display("FAIL error_mem_word0: got %h expected %h", last_rd, w0);
    end
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h8, 32'h0));
    run_ops();
    checks++;
    if (last_rd !== w2) begin
      failures++;
      $display("FAIL error_mem_word2: got %h expected %h", last_rd, w2);
    end
    dsel = 2'd1;
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, BASE + 32'h41, 32'h00BEEF00));
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h40, 32'h0));
    run_ops();
    checks++;
    if (resp_cycles !== exp_resp1 || low_cycles !== exp_low1) begin
      failures++;
      $display("FAIL error_wait_inst: got resp=%0d low=%0d expected resp=%0d low=%0d",
               resp_cycles, low_cycles, exp_resp1, exp_low1);
    end
  endtask

  task automatic test_idle_busy();
    op_t o;
    dsel = 2'd0;
    q.push_back(mk(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h50, 32'hA5A5A5A5));
    q.push_back(mk(HTRANS_IDLE,   1'b1, HSIZE_WORD, BASE + 32'h54, 32'h12345678));
    q.push_back(mk(HTRANS_SEQ,    1'b1, HSIZE_WORD, BASE + 32'h58, 32'h5A5A5A5A));
    q.push_back(mk(HTRANS_BUSY,   1'b1, HSIZE_WORD, BASE + 32'h54, 32'h87654321));
    o = mk(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, BASE + 32'h54, 32'hFFFF0000);
    o.sel = 1'b0;
    q.push_back(o);
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h54, 32'h0));
    run_ops();
    checks++;
    if (last_rd !== mdl[0][21]) begin
      failures++;
      $display("FAIL idle_busy_untouched: got %h expected %h", last_rd, mdl[0][21]);
    end
    checks++;
    if (low_cycles !== 0) begin
      failures++;
      $display("FAIL idle_busy_zero_wait: got %0d low cycles expected 0", low_cycles);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      dsel = 2'(k);
      for (int i = 0; i < 150; i++) q.push_back(rand_op());
      for (int i = 0; i < 16; i++)
        q.push_back(mk(HTRANS_SEQ, 1'b0, HSIZE_WORD, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0));
      run_ops();
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] old;
    dsel = 2'd2;
    old  = mdl[2][16];
    @(negedge hclk);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; hsize = HSIZE_WORD; haddr = BASE + 32'h40;
    @(negedge hclk);
    htrans = HTRANS_IDLE; hwdata = ~old;
    checks++;
    if (hready_m !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_pre_wait: got %b expected 0", hready_m);
    end
    @(negedge hclk);
    #2 hrstn = 1'b0;
    #1;
    checks++;
    if (hready_m !== 1'b1 || hresp_m !== 1'b0 || hrdata_m !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs: got rdy=%b resp=%b rd=%h expected 1 0 0", hready_m, hresp_m, hrdata_m);
    end
    @(negedge hclk); hrstn = 1'b1;
    q.push_back(mk(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, BASE + 32'h40, 32'h0));
    run_ops();
    checks++;
    if (last_rd !== old) begin
      failures++;
      $display("FAIL mid_reset_mem_kept: got %h expected %h", last_rd, old);
    end
  endtask

  initial begin
    hrstn = 1'b0; hsel = 1'b1; htrans = HTRANS_IDLE; haddr = 32'd0; hwrite = 1'b0;
    hsize = HSIZE_WORD; hwdata = 32'd0; dsel = 2'd0; last_rd = 32'd0;
    repeat (3) @(negedge hclk);
    test_reset();
    test_preload();
    test_word_roundtrip();
    test_lanes();
    test_wait_states();
    test_error();
    test_idle_busy();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
